theta_stage: RTL and testbench

- Registered Keccak-f[1600] theta step. It sits directly upstream of rho in the round datapath and drives rho's A_in from its A_out.
- Computes the column parities C[x], then D[x] = C[x-1] ^ rotl(C[x+1],1), then A_out[x][y] = A_in[x][y] ^ D[x]. All x indices are mod 5.
- Elastic valid/ready pipeline, 1 or 2 register stages, full throughput (one state per cycle).
- State indexing is A[x][y][z], matching rho: x = first index, y = second, z = bit, lane bit 0 = LSB.

---
 rtl/theta_stage.sv | 151 +++++++++++++++
 tb/tb_theta_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/theta_stage.sv
`default_nettype none
// ============================================================================
//  Module   : theta_stage
//  Purpose  : Registered Keccak-f[1600] theta step with an elastic
//             valid/ready pipeline of 1 or 2 register stages.
//             C[x] = XOR_y A[x][y]
//             D[x] = C[x-1] ^ rotl(C[x+1], 1)      (x mod 5)
//             A_out[x][y] = A_in[x][y] ^ D[x]
//  Ports    : clk       - rising-edge clock
//             rst       - asynchronous active-high reset
//             in_valid  - A_in holds a valid state
//             in_ready  - stage accepts A_in this cycle
//             A_in      - input state, A[x][y][z], lane bit 0 = LSB
//             out_valid - A_out holds a valid theta result
//             out_ready - downstream accepts A_out
//             A_out     - registered theta output
//  Revision : 1.0  initial release
// ============================================================================
module theta_stage #(
  parameter int W      = 64,  // lane width, any value >= 2
  parameter int STAGES = 2    // 1 or 2; any other value builds two stages
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A_in  [0:4][0:4],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] A_out [0:4][0:4]
);

  // Column parities and the per-column theta correction of the input state.
  logic [W-1:0] w_c [0:4];
  logic [W-1:0] w_d [0:4];

  for (genvar x = 0; x < 5; x++) begin : g_col
    assign w_c[x] = A_in[x][0] ^ A_in[x][1] ^ A_in[x][2] ^ A_in[x][3] ^ A_in[x][4];
    // rotl by one: the MSB of C[x+1] wraps into bit 0
    assign w_d[x] = w_c[(x + 4) % 5] ^ {w_c[(x + 1) % 5][W-2:0], w_c[(x + 1) % 5][W-1]};
  end

  if (STAGES == 1) begin : g_one
    logic         r_v;
    logic [W-1:0] r_a     [0:4][0:4];
    logic [W-1:0] w_theta [0:4][0:4];
    logic         w_adv;

    for (genvar x = 0; x < 5; x++) begin : g_tx
      for (genvar y = 0; y < 5; y++) begin : g_ty
        assign w_theta[x][y] = A_in[x][y] ^ w_d[x];
      end
    end

    assign w_adv = !r_v || out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        for (int x = 0; x < 5; x++)
          for (int y = 0; y < 5; y++)
            r_a[x][y] <= '0;
      end else if (w_adv) begin
        r_v <= in_valid;
        // only a valid state overwrites the register; bubbles leave it alone
        if (in_valid) begin
          for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
              r_a[x][y] <= w_theta[x][y];
        end
      end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_v;
    for (genvar x = 0; x < 5; x++) begin : g_ox
      for (genvar y = 0; y < 5; y++) begin : g_oy
        assign A_out[x][y] = r_a[x][y];
      end
    end

  end else begin : g_two
    // Stage 1 holds the raw state plus D; stage 2 holds A ^ D. Splitting
    // here puts the parity tree and the final XOR in separate cycles.
    logic         r_v1;
    logic [W-1:0] r_a1 [0:4][0:4];
    logic [W-1:0] r_d1 [0:4];
    logic         r_v2;
    logic [W-1:0] r_a2 [0:4][0:4];
    logic [W-1:0] w_s2 [0:4][0:4];
    logic         w_adv1;
    logic         w_adv2;

    for (genvar x = 0; x < 5; x++) begin : g_tx
      for (genvar y = 0; y < 5; y++) begin : g_ty
        assign w_s2[x][y] = r_a1[x][y] ^ r_d1[x];
      end
    end

    // Each stage moves when it is empty or the next one is moving, so a
    // full pipe with out_ready high shifts every stage without a bubble.
    assign w_adv2 = !r_v2 || out_ready;
    assign w_adv1 = !r_v1 || w_adv2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v1 <= 1'b0;
        for (int x = 0; x < 5; x++) begin
          r_d1[x] <= '0;
          for (int y = 0; y < 5; y++)
            r_a1[x][y] <= '0;
        end
      end else if (w_adv1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          for (int x = 0; x < 5; x++) begin
            r_d1[x] <= w_d[x];
            for (int y = 0; y < 5; y++)
              r_a1[x][y] <= A_in[x][y];
          end
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v2 <= 1'b0;
        for (int x = 0; x < 5; x++)
          for (int y = 0; y < 5; y++)
            r_a2[x][y] <= '0;
      end else if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
              r_a2[x][y] <= w_s2[x][y];
        end
      end
    end

    assign in_ready  = w_adv1;
    assign out_valid = r_v2;
    for (genvar x = 0; x < 5; x++) begin : g_ox
      for (genvar y = 0; y < 5; y++) begin : g_oy
        assign A_out[x][y] = r_a2[x][y];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_theta_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_theta_stage
//  Purpose  : Self-checking bench for theta_stage: directed vectors,
//             backpressure, random streaming and mid-flight reset, compared
//             against a bit-level theta reference and an in-flight queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_theta_stage;

  localparam int W      = 64;
  localparam int STAGES = 2;
  typedef logic [25*W-1:0] flat_t;   // lane (x,y) at bits (x*5+y)*W +: W

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A_in  [0:4][0:4];
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] A_out [0:4][0:4];

  theta_stage #(.W(W), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .A_in(A_in),
    .out_valid(out_valid), .out_ready(out_ready), .A_out(A_out)
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  int    n_emit = 0;
  bit    in_fire, out_fire;
  flat_t cur_in = '0;
  flat_t exp_q [$];

  // ---------------- reference model ----------------
  function automatic flat_t theta_ref(input flat_t a);
    flat_t r;
    logic  c [0:4][0:W-1];
    for (int x = 0; x < 5; x++)
      for (int z = 0; z < W; z++) begin
        c[x][z] = 1'b0;
        for (int y = 0; y < 5; y++) c[x][z] ^= a[(x*5+y)*W + z];
      end
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        for (int z = 0; z < W; z++)
          r[(x*5+y)*W + z] = a[(x*5+y)*W + z] ^ c[(x+4)%5][z]
                             ^ c[(x+1)%5][(z+W-1)%W];
    return r;
  endfunction

  function automatic flat_t put(input flat_t f, input int x, input int y,
                                input logic [W-1:0] v);
    flat_t r = f;
    r[(x*5+y)*W +: W] = v;
    return r;
  endfunction

  function automatic flat_t rand_state();
    flat_t f;
    for (int i = 0; i < 25*W/32; i++) f[i*32 +: 32] = $urandom();
    return f;
  endfunction

  function automatic flat_t pack_out();
    flat_t f;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) f[(x*5+y)*W +: W] = A_out[x][y];
    return f;
  endfunction

  task automatic set_in(input flat_t f);
    cur_in = f;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) A_in[x][y] = f[(x*5+y)*W +: W];
  endtask

  // ---------------- checkers ----------------
  task automatic check1(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input flat_t obs, input flat_t exp);
    bit found;
    tests++;
    assert (obs === exp) else begin
      fails++;
      found = 0;
      for (int k = 0; k < 25; k++)
        if (!found && obs[k*W +: W] !== exp[k*W +: W]) begin
          found = 1;
          $error("FAIL %s lane[%0d][%0d] got %h expected %h", tag, k/5, k%5,
                 obs[k*W +: W], exp[k*W +: W]);
        end
    end
  endtask

  // One clock: called 1 time unit after a rising edge with inputs set.
  // Checks in_ready against occupancy and output data against the queue,
  // then crosses the next edge and updates the model.
  task automatic cycle();
    flat_t nxt;
    #4;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    check1("in_ready", in_ready, !(exp_q.size() == STAGES && !out_ready));
    if (out_valid) begin
      if (exp_q.size() == 0) check1("out_valid_empty", out_valid, 0);
      else check_state("out_data", pack_out(), exp_q[0]);
    end
    nxt = theta_ref(cur_in);
    @(posedge clk); #1;
    if (out_fire && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      n_emit++;
    end
    if (in_fire) exp_q.push_back(nxt);
  endtask

  // Single state with no backpressure: out_valid must appear exactly
  // STAGES edges after the accepting edge, carrying exp_hard.
  task automatic run_one(input string tag, input flat_t s, input flat_t exp_hard);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_in(s);
    cycle();
    check1({tag, "_accept"}, in_fire, 1);
    in_valid = 1'b0;
    for (int k = 1; k <= STAGES; k++) begin
      check1({tag, "_latency"}, out_valid, k == STAGES);
      if (k == STAGES) check_state({tag, "_value"}, pack_out(), exp_hard);
      cycle();
    end
  endtask

  flat_t s_bp [0:2];
  flat_t s_st [0:99];
  flat_t e;
  int    idx, cyc;

  initial begin
    set_in('0);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 0);
    check_state("rst_A_out", pack_out(), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check1("rst_in_ready", in_ready, 1);

    // zero state
    run_one("zero", '0, '0);

    // single bit at [0][0]
    e = put('0, 0, 0, 64'h1);
    for (int y = 0; y < 5; y++) begin
      e = put(e, 1, y, 64'h1);
      e = put(e, 4, y, 64'h2);
    end
    run_one("single_bit", put('0, 0, 0, 64'h1), e);

    // MSB at [2][3] wraps into bit 0 of column 1
    e = put('0, 2, 3, 64'h8000_0000_0000_0000);
    for (int y = 0; y < 5; y++) begin
      e = put(e, 1, y, 64'h1);
      e = put(e, 3, y, 64'h8000_0000_0000_0000);
    end
    run_one("rot_wrap", put('0, 2, 3, 64'h8000_0000_0000_0000), e);

    // backpressure: 5 stalled cycles offering S0,S1,S2
    for (int i = 0; i < 3; i++) s_bp[i] = rand_state();
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      set_in(s_bp[idx]);
      cycle();
      if (in_fire) idx++;
    end
    check1("bp_accepted", idx, STAGES);
    check1("bp_in_ready", in_ready, 0);
    check1("bp_out_valid", out_valid, 1);
    check_state("bp_hold", pack_out(), theta_ref(s_bp[0]));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = (idx < 3);
      if (idx < 3) set_in(s_bp[idx]);
      cycle();
      check1("bp_consecutive", out_fire, 1);
      if (in_fire) idx++;
    end
    in_valid = 1'b0;

    // random streaming, out_ready high ~70% of cycles
    for (int i = 0; i < 100; i++) s_st[i] = rand_state();
    n_emit = 0;
    idx = 0;
    cyc = 0;
    while (n_emit < 100 && cyc < 2000) begin
      in_valid = (idx < 100);
      if (idx < 100) set_in(s_st[idx]);
      out_ready = ($urandom_range(0, 99) < 70);
      cycle();
      if (in_fire) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check1("stream_count", n_emit, 100);
    check1("stream_queue_empty", exp_q.size(), 0);

    // mid-flight reset with two states in the pipe
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      set_in(rand_state());
      cycle();
    end
    in_valid = 1'b0;
    check1("mr_full_out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check1("mr_out_valid_async", out_valid, 0);
    check_state("mr_A_out_zero", pack_out(), '0);
    exp_q.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check1("mr_no_stale", out_valid, 0);
    set_in(rand_state());
    run_one("mr_next", cur_in, theta_ref(cur_in));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
